cmd_response_receiver: RTL and testbench

- Downstream companion of the SD command physical stage (cmd_phys): once a command frame has been driven on the CMD line, this block listens on the same line for the card's response.
- It detects the start bit and deserializes a 48-bit short response or a 136-bit R2 response.
- It checks the CRC7 and the end bit, enforces the NCR response timeout, and reports the result to the command controller through a one-cycle done pulse with status flags.

---
 rtl/cmd_response_receiver.sv | 142 ++++++++++++++
 tb/tb_cmd_response_receiver.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cmd_response_receiver.sv
// SD CMD-line response receiver: waits for the card's start bit, deserializes
// a 48-bit short or 136-bit R2 response, checks CRC7 and end bit, and reports
// the result with a one-cycle done pulse and held status flags.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// IDLE       | waiting for enable_in; outputs and flags hold last result
// WAIT_START | line idle-high; counting NCR cycles until start bit or timeout
// RECEIVE    | shifting one frame bit per sd_clock, MSB first
// CHECK      | compare computed CRC7 against received field, test end bit
// DONE       | done_out high for one cycle, then back to IDLE
module cmd_response_receiver #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int SHORT_BITS     = 48,
  parameter int LONG_BITS      = 136
) (
  input  logic         sd_clock,
  input  logic         reset,
  input  logic         enable_in,
  input  logic         long_resp_in,
  input  logic         check_crc_in,
  input  logic         TIMEOUT_ENABLE,
  input  logic         cmd_pin_in,
  output logic [135:0] response_out,
  output logic         busy_out,
  output logic         done_out,
  output logic         crc_error_out,
  output logic         end_error_out,
  output logic         timeout_out
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WAIT_START = 3'd1;
  localparam logic [2:0] RECEIVE    = 3'd2;
  localparam logic [2:0] CHECK      = 3'd3;
  localparam logic [2:0] DONE       = 3'd4;

  localparam int CNT_W = $clog2(LONG_BITS + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] SHORT_N         = CNT_W'(SHORT_BITS);
  localparam logic [CNT_W-1:0] LONG_N          = CNT_W'(LONG_BITS);
  // Short frames cover start bit through argument; R2 skips its 8-bit header.
  localparam logic [CNT_W-1:0] SHORT_CRC_LAST  = CNT_W'(SHORT_BITS - 8);
  localparam logic [CNT_W-1:0] LONG_CRC_FIRST  = CNT_W'(9);
  localparam logic [CNT_W-1:0] LONG_CRC_LAST   = CNT_W'(LONG_BITS - 8);
  localparam logic [TMO_W-1:0] TMO_LIMIT       = TMO_W'(TIMEOUT_CYCLES);

  logic [2:0]       state;
  logic [CNT_W-1:0] bit_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [6:0]       crc;
  logic             long_q;
  logic             check_q;

  logic [CNT_W-1:0] bit_num;
  logic [CNT_W-1:0] frame_n;
  logic             crc_window;
  logic [6:0]       crc_next;
  logic [TMO_W-1:0] tmo_inc;

  // Position of the bit being sampled this cycle, and whether it feeds the CRC.
  always_comb begin
    bit_num    = bit_cnt + CNT_W'(1);
    frame_n    = long_q ? LONG_N : SHORT_N;
    crc_window = long_q ? ((bit_num >= LONG_CRC_FIRST) && (bit_num <= LONG_CRC_LAST))
                        : (bit_num <= SHORT_CRC_LAST);
    crc_next   = {crc[5:0], 1'b0} ^ ({7{cmd_pin_in ^ crc[6]}} & 7'h09);
    // Saturating so a late switch of TIMEOUT_ENABLE still hits the limit.
    tmo_inc    = (tmo_cnt == TMO_LIMIT) ? tmo_cnt : tmo_cnt + TMO_W'(1);
  end

  // Main sequencer: frame capture, CRC accumulation, timeout and result flags.
  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      tmo_cnt       <= '0;
      crc           <= '0;
      long_q        <= 1'b0;
      check_q       <= 1'b0;
      response_out  <= '0;
      crc_error_out <= 1'b0;
      end_error_out <= 1'b0;
      timeout_out   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable_in) begin
            state         <= WAIT_START;
            long_q        <= long_resp_in;
            check_q       <= check_crc_in;
            bit_cnt       <= '0;
            tmo_cnt       <= '0;
            crc           <= '0;
            response_out  <= '0;
            crc_error_out <= 1'b0;
            end_error_out <= 1'b0;
            timeout_out   <= 1'b0;
          end
        end
        WAIT_START: begin
          if (!cmd_pin_in) begin
            // Start bit takes priority over a timeout landing on this cycle.
            state        <= RECEIVE;
            response_out <= {response_out[134:0], cmd_pin_in};
            bit_cnt      <= bit_num;
            if (crc_window) crc <= crc_next;
          end else begin
            tmo_cnt <= tmo_inc;
            if (TIMEOUT_ENABLE && (tmo_inc == TMO_LIMIT)) begin
              timeout_out <= 1'b1;
              state       <= DONE;
            end
          end
        end
        RECEIVE: begin
          response_out <= {response_out[134:0], cmd_pin_in};
          bit_cnt      <= bit_num;
          if (crc_window) crc <= crc_next;
          if (bit_num == frame_n) state <= CHECK;
        end
        CHECK: begin
          // Received CRC sits just above the end bit for both frame lengths.
          crc_error_out <= check_q && (crc != response_out[7:1]);
          end_error_out <= ~response_out[0];
          state         <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy_out = (state != IDLE);
  assign done_out = (state == DONE);

endmodule

// File: tb/tb_cmd_response_receiver.sv
// Directed bench for cmd_response_receiver: table of response frames with
// hand-computed flags, plus timeout, NCR-limit, mid-frame enable and reset
// sequences.
module tb_cmd_response_receiver;

  logic         sd_clock = 1'b0;
  logic         reset;
  logic         enable_in;
  logic         long_resp_in;
  logic         check_crc_in;
  logic         TIMEOUT_ENABLE;
  logic         cmd_pin_in;
  logic [135:0] response_out;
  logic         busy_out;
  logic         done_out;
  logic         crc_error_out;
  logic         end_error_out;
  logic         timeout_out;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [135:0] frame;
    int           nbits;
    logic         long_r;
    logic         chk;
    logic         exp_crc;
    logic         exp_end;
  } vec_t;

  vec_t vecs[6];

  cmd_response_receiver dut (
    .sd_clock       (sd_clock),
    .reset          (reset),
    .enable_in      (enable_in),
    .long_resp_in   (long_resp_in),
    .check_crc_in   (check_crc_in),
    .TIMEOUT_ENABLE (TIMEOUT_ENABLE),
    .cmd_pin_in     (cmd_pin_in),
    .response_out   (response_out),
    .busy_out       (busy_out),
    .done_out       (done_out),
    .crc_error_out  (crc_error_out),
    .end_error_out  (end_error_out),
    .timeout_out    (timeout_out)
  );

  always #5 sd_clock = ~sd_clock;

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bit-serial CRC7 (x^7+x^3+1) reference, MSB first.
  function automatic logic [6:0] crc7(input logic [119:0] d, input int n);
    logic [6:0] c = '0;
    for (int i = n - 1; i >= 0; i--) begin
      logic fb = d[i] ^ c[6];
      c = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  task automatic pulse_enable(input logic long_r, input logic chk_r);
    @(negedge sd_clock);
    long_resp_in = long_r;
    check_crc_in = chk_r;
    enable_in    = 1'b1;
    @(negedge sd_clock);
    enable_in    = 1'b0;
    // Flip the mode inputs so a design that fails to latch them is caught.
    long_resp_in = ~long_r;
    check_crc_in = ~chk_r;
  endtask

  // Drive a frame MSB first, then check the CHECK/DONE timing and results.
  task automatic drive_and_check(input vec_t v, input int enable_at, input string tag);
    for (int i = v.nbits - 1; i >= 0; i--) begin
      cmd_pin_in = v.frame[i];
      enable_in  = (i == enable_at);
      @(negedge sd_clock);
    end
    enable_in  = 1'b0;
    cmd_pin_in = 1'b1;
    chk({tag, "_check_cycle_done"}, 136'(done_out), 136'd0);
    @(negedge sd_clock);
    chk({tag, "_done"}, 136'(done_out), 136'd1);
    chk({tag, "_response"}, response_out, v.frame);
    chk({tag, "_flags"}, 136'({crc_error_out, end_error_out, timeout_out}),
        136'({v.exp_crc, v.exp_end, 1'b0}));
    @(negedge sd_clock);
    chk({tag, "_after_done"}, 136'({done_out, busy_out}), 136'd0);
    chk({tag, "_held"}, 136'({crc_error_out, end_error_out}), 136'({v.exp_crc, v.exp_end}));
  endtask

  task automatic run_vec(input vec_t v, input int gap, input int enable_at, input string tag);
    pulse_enable(v.long_r, v.chk);
    chk({tag, "_armed"}, 136'({busy_out, crc_error_out, end_error_out, timeout_out}), 136'b1000);
    chk({tag, "_cleared"}, response_out, 136'd0);
    cmd_pin_in = 1'b1;
    repeat (gap) @(negedge sd_clock);
    drive_and_check(v, enable_at, tag);
  endtask

  initial begin
    logic [119:0] payload;
    logic [6:0]   lcrc;
    logic         bad;

    payload = 120'h0123456789ABCDEFFEDCBA98765432;
    lcrc    = crc7(payload, 120);

    vecs[0] = '{136'h400000000095, 48, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{136'h400000000093, 48, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{136'h400000000093, 48, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{136'h48000001AA86, 48, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{136'h400000000092, 48, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{{8'h3F, payload, lcrc, 1'b1}, 136, 1'b1, 1'b1, 1'b0, 1'b0};

    reset          = 1'b0;
    enable_in      = 1'b0;
    long_resp_in   = 1'b0;
    check_crc_in   = 1'b0;
    TIMEOUT_ENABLE = 1'b1;
    cmd_pin_in     = 1'b1;
    repeat (3) @(negedge sd_clock);
    chk("reset_outputs", 136'({busy_out, done_out, crc_error_out, end_error_out, timeout_out}), 136'd0);
    chk("reset_response", response_out, 136'd0);
    reset = 1'b1;
    @(negedge sd_clock);

    for (int k = 0; k < 6; k++) begin
      // The long frame carries a mid-frame enable pulse that must be ignored.
      run_vec(vecs[k], 3, (k == 5) ? 70 : -1, $sformatf("vec%0d", k));
    end

    // Start bit on the 64th sample beats the timeout.
    run_vec(vecs[0], 63, -1, "ncr_limit");

    // Line held high: timeout after exactly 64 high samples.
    pulse_enable(1'b0, 1'b1);
    cmd_pin_in = 1'b1;
    bad = 1'b0;
    repeat (63) begin
      @(negedge sd_clock);
      if (done_out || !busy_out) bad = 1'b1;
    end
    chk("tmo_no_early_done", 136'(bad), 136'd0);
    @(negedge sd_clock);
    chk("tmo_done", 136'({done_out, timeout_out}), 136'b11);
    chk("tmo_other_flags", 136'({crc_error_out, end_error_out}), 136'd0);
    @(negedge sd_clock);
    chk("tmo_after", 136'({done_out, busy_out, timeout_out}), 136'b001);

    // Timeout disabled: keep waiting, then a late frame still completes.
    TIMEOUT_ENABLE = 1'b0;
    pulse_enable(1'b0, 1'b1);
    cmd_pin_in = 1'b1;
    chk("notmo_cleared", 136'(timeout_out), 136'd0);
    bad = 1'b0;
    repeat (500) begin
      @(negedge sd_clock);
      if (done_out || !busy_out) bad = 1'b1;
    end
    chk("notmo_wait", 136'(bad), 136'd0);
    drive_and_check(vecs[0], -1, "notmo_frame");
    TIMEOUT_ENABLE = 1'b1;

    // Reset partway through a short frame.
    pulse_enable(1'b0, 1'b1);
    cmd_pin_in = 1'b1;
    repeat (3) @(negedge sd_clock);
    for (int i = 47; i >= 28; i--) begin
      cmd_pin_in = vecs[0].frame[i];
      @(negedge sd_clock);
    end
    chk("rst_partial", response_out, {116'd0, vecs[0].frame[47:28]});
    #2 reset = 1'b0;
    #1;
    chk("rst_async_outputs", 136'({busy_out, done_out, crc_error_out, end_error_out, timeout_out}), 136'd0);
    chk("rst_async_response", response_out, 136'd0);
    cmd_pin_in = 1'b1;
    @(negedge sd_clock);
    reset = 1'b1;
    @(negedge sd_clock);
    chk("rst_idle", 136'({busy_out, done_out}), 136'd0);
    run_vec(vecs[0], 3, -1, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
